vec_mem_sequencer: RTL and testbench
====================================

VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

Interface
REQ-001 SHALL have parameter V, default 128: vector width in bits.
REQ-002 SHALL have parameter N, default 32: lane and memory word width; LANES = V/N, which is 4.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_s  in  1  scalar memory access request.
REQ-006 req_v  in  1  vector memory access request.
REQ-007 we  in  1  access is a store (1) or a load (0).
REQ-008 addr_vec  in  V  per-lane addresses; lane i is [N*i+N-1:N*i]; scalar uses lane 0.
REQ-009 wdata_vec  in  V  per-lane store data; scalar uses lane 0.
REQ-010 mem_rdata  in  N  memory read data, valid one cycle after its address.
REQ-011 mem_addr  out  N  memory address.
REQ-012 mem_wdata  out  N  memory write data.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 rdata_vec  out  V  assembled vector load result.
REQ-015 done  out  1  one-cycle pulse when a vector operation completes.
REQ-016 stall_cpu  out  1  hold the CPU pipeline.

Function
REQ-017 FSM states SHALL be IDLE, BEAT, DRAIN and DONE.
REQ-018 IDLE with req_v=1 (cycle T): SHALL latch addr_vec, wdata_vec and we, clear the beat counter, and go to BEAT.
REQ-019 BEAT SHALL issue lane k in cycle T+1+k, k=0..3: mem_addr=lane k address, mem_wdata=lane k data, mem_we=latched we.
REQ-020 In BEAT, the beat counter SHALL increment each cycle; after k=3 the FSM SHALL go to DRAIN.
REQ-021 For loads, mem_rdata in cycles T+2..T+5 SHALL be registered into rdata_vec lanes 0..3 respectively.
REQ-022 Cycle T+5 SHALL be DRAIN: mem_we=0, mem_addr=0.
REQ-023 Cycle T+6 SHALL be DONE: done=1, stall_cpu=0, rdata_vec complete; next state IDLE.
REQ-024 stall_cpu SHALL be 1 in cycles T..T+5: combinational from req_v in IDLE, registered state thereafter.
REQ-025 IDLE with req_s=1 and req_v=0: SHALL pass through combinationally with mem_addr=addr_vec[N-1:0], mem_wdata=wdata_vec[N-1:0], mem_we=we, stall_cpu=0.
REQ-026 req_s and req_v both 1 in IDLE: the vector request SHALL win and the scalar request SHALL be ignored.
REQ-027 req_s and req_v SHALL be ignored outside IDLE; input changes after T SHALL not affect the operation in progress.
REQ-028 IDLE with no request: mem_addr, mem_wdata and mem_we SHALL be 0.
REQ-029 A vector store SHALL leave rdata_vec unchanged.
REQ-030 rdata_vec SHALL hold its value until the next vector load or reset.
REQ-031 req_v=1 in the DONE cycle SHALL not be accepted; acceptance is earliest at T+7, giving back-to-back operations a 7-cycle period.

Reset
REQ-032 rst=1 SHALL, at the next edge, force IDLE and clear the beat counter, rdata_vec and latched operands.
REQ-033 rst=1 SHALL set outputs mem_addr=0, mem_wdata=0, mem_we=0, done=0 and stall_cpu=0.
REQ-034 Reset mid-operation SHALL abort with no further memory beats issued.

Configuration
REQ-035 With VMS_STALL_CNT_EN defined: SHALL add output stall_cnt [31:0], incremented on every cycle with stall_cpu=1, wrapping at 2^32, cleared by rst.
REQ-036 Without VMS_STALL_CNT_EN: SHALL have no port stall_cnt and no counter logic.

Structure
REQ-037 Package vms_pkg SHALL hold the state enum type, the LANES constant and the beat-index typedef (2 bits).
REQ-038 Sub-module vms_beat_counter SHALL provide the beat counter: clear, enable, 2-bit count, last-beat flag.

Verification
REQ-039 Vector load: addr_vec={0x0C,0x08,0x04,0x00}, memory holds 0x11,0x22,0x33,0x44 at those addresses.
- mem_addr SHALL be 0x00,0x04,0x08,0x0C in T+1..T+4.
- done SHALL be 1 at T+6 with rdata_vec={0x44,0x33,0x22,0x11}.
- stall_cpu SHALL be 1 for exactly 6 cycles.
REQ-040 Vector store: we=1, wdata_vec={D,C,B,A}.
- mem_we SHALL be 1 in exactly T+1..T+4 with lane data A..D.
- rdata_vec SHALL stay unchanged.
REQ-041 Scalar store: req_s=1, addr 0x20, data 0x5A.
- Same cycle: mem_addr=0x20, mem_wdata=0x5A, mem_we=1, stall_cpu=0.
REQ-042 Simultaneous req_s and req_v in IDLE:
- Only the vector sequence SHALL occur.
- req_s pulses during BEAT SHALL produce no memory access.
REQ-043 rst asserted at T+3 of a load:
- Next cycle: IDLE, all outputs 0, rdata_vec=0.
- A new req_v SHALL then run a full, correct sequence.
REQ-044 With VMS_STALL_CNT_EN defined: two back-to-back vector operations SHALL give stall_cnt=12.

Source files
------------

// File: rtl/vec_mem_sequencer_pkg.sv
// vms_pkg: types and constants shared by the vector memory sequencer.
//   vms_state_e : sequencer FSM state encoding
//   LANES       : lanes per vector (V/N with default parameters)
//   beat_idx_t  : 2-bit beat / lane index
package vms_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vms_state_e;

  typedef logic [1:0] beat_idx_t;

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// vec_mem_sequencer_if: CPU request/response and memory bus bundle.
//   CPU side   : req_s, req_v, we, addr_vec, wdata_vec -> rdata_vec, done, stall_cpu
//   Memory side: mem_addr, mem_wdata, mem_we -> mem_rdata
//   slave  modport : the sequencer's view
//   master modport : the CPU + memory environment's view
interface vec_mem_sequencer_if #(
  parameter int V = 128,
  parameter int N = 32
) ();

  logic         req_s;
  logic         req_v;
  logic         we;
  logic [V-1:0] addr_vec;
  logic [V-1:0] wdata_vec;
  logic [V-1:0] rdata_vec;
  logic         done;
  logic         stall_cpu;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic [N-1:0] mem_rdata;

  modport slave (
    input  req_s, req_v, we, addr_vec, wdata_vec, mem_rdata,
    output mem_addr, mem_wdata, mem_we, rdata_vec, done, stall_cpu
  );

  modport master (
    output req_s, req_v, we, addr_vec, wdata_vec, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, rdata_vec, done, stall_cpu
  );

endinterface

// File: rtl/vec_mem_sequencer_beat_counter.sv
// vms_beat_counter: 2-bit beat counter for the vector sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (priority over en)
//   en       : increment count (wraps 3 -> 0)
//   cnt      : current beat index
//   last     : cnt is the final lane
module vms_beat_counter
  import vms_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      en,
  output beat_idx_t cnt,
  output logic      last
);

  beat_idx_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == beat_idx_t'(LANES - 1));

endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: splits a vector load/store into one memory beat per lane
// and reassembles load data; scalar accesses pass straight through in IDLE.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : vec_mem_sequencer_if.slave (CPU request/response + memory bus)
//   stall_cnt : cycles with stall_cpu=1 (only when VMS_STALL_CNT_EN is defined)
// Optional feature macro: VMS_STALL_CNT_EN
//
// state | meaning
// IDLE  | waiting; scalar pass-through, vector request latched here (cycle T)
// BEAT  | lane k issued to memory in T+1+k, k = 0..3
// DRAIN | bus idle, last load word captured (T+5)
// DONE  | done pulse, stall released (T+6)
module vec_mem_sequencer
  import vms_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VMS_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  vec_mem_sequencer_if.slave bus
);

  vms_state_e   state_q, state_d;
  logic [V-1:0] addr_l_q, addr_l_d;
  logic [V-1:0] wdata_l_q, wdata_l_d;
  logic         we_l_q, we_l_d;
  logic [V-1:0] rdata_q, rdata_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] mem_wdata_q, mem_wdata_d;
  logic         mem_we_q, mem_we_d;
  logic         done_q, done_d;
  logic         stall_q, stall_d;

  logic         cnt_clr, cnt_en, last;
  beat_idx_t    cnt, nxt_lane, cap_lane;

  vms_beat_counter u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (last)
  );

  // Memory outputs are registered one cycle ahead: the value computed while
  // the current lane is on the bus is the next lane's beat. Load data trails
  // its address by one cycle, so the capture lane is cnt-1; in DRAIN the
  // counter has wrapped to 0, which makes cnt-1 the final lane.
  always_comb begin
    state_d     = state_q;
    addr_l_d    = addr_l_q;
    wdata_l_d   = wdata_l_q;
    we_l_d      = we_l_q;
    rdata_d     = rdata_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    stall_d     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    nxt_lane    = cnt + 2'd1;
    cap_lane    = cnt - 2'd1;

    case (state_q)
      IDLE: begin
        if (bus.req_v) begin
          state_d     = BEAT;
          addr_l_d    = bus.addr_vec;
          wdata_l_d   = bus.wdata_vec;
          we_l_d      = bus.we;
          cnt_clr     = 1'b1;
          mem_addr_d  = bus.addr_vec[N-1:0];
          mem_wdata_d = bus.wdata_vec[N-1:0];
          mem_we_d    = bus.we;
          stall_d     = 1'b1;
        end
      end
      BEAT: begin
        cnt_en  = 1'b1;
        stall_d = 1'b1;
        if (!we_l_q && (cnt != '0)) begin
          rdata_d[int'(cap_lane)*N +: N] = bus.mem_rdata;
        end
        if (last) begin
          state_d = DRAIN;
        end else begin
          mem_addr_d  = addr_l_q[int'(nxt_lane)*N +: N];
          mem_wdata_d = wdata_l_q[int'(nxt_lane)*N +: N];
          mem_we_d    = we_l_q;
        end
      end
      DRAIN: begin
        if (!we_l_q) begin
          rdata_d[int'(cap_lane)*N +: N] = bus.mem_rdata;
        end
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_l_q    <= '0;
      wdata_l_q   <= '0;
      we_l_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_l_q    <= addr_l_d;
      wdata_l_q   <= wdata_l_d;
      we_l_q      <= we_l_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      stall_q     <= stall_d;
    end
  end

  // In IDLE the bus follows the CPU directly (scalar pass-through, vector
  // stall); elsewhere it shows the registered beat. rst masks everything so a
  // reset cycle never issues a write.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.done      = 1'b0;
    bus.stall_cpu = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) begin
        bus.stall_cpu = bus.req_v;
        if (bus.req_s && !bus.req_v) begin
          bus.mem_addr  = bus.addr_vec[N-1:0];
          bus.mem_wdata = bus.wdata_vec[N-1:0];
          bus.mem_we    = bus.we;
        end
      end else begin
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.mem_we    = mem_we_q;
        bus.stall_cpu = stall_q;
      end
      bus.done = done_q;
    end
  end

  assign bus.rdata_vec = rdata_q;

`ifdef VMS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall_cpu) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;

  localparam int V = 128;
  localparam int N = 32;

  logic clk;
  logic rst;
`ifdef VMS_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  vec_mem_sequencer_if #(.V(V), .N(N)) bus ();

  vec_mem_sequencer #(.V(V), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef VMS_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory: 64 words, word index addr[7:2], read data one cycle after address.
  // Reset loads a known pattern so load results are predictable.
  logic [N-1:0] mem [64];
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      mem[3] = 32'h44;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] = bus.mem_wdata;
    end
  end

  // Reference model: tracks how many cycles have passed since a vector
  // request was accepted and derives every output from that offset.
  int           phase = -1;
  logic [V-1:0] m_addr = '0;
  logic [V-1:0] m_wdata = '0;
  logic         m_we = 1'b0;
  logic [V-1:0] exp_rdata = '0;

  always @(negedge clk) begin : model_cmp
    logic [N-1:0] e_addr, e_wdata;
    logic         e_we, e_done, e_stall;
    e_addr = '0; e_wdata = '0; e_we = 1'b0; e_done = 1'b0; e_stall = 1'b0;
    if (rst) begin
      // everything quiet during reset
    end else if (phase < 0) begin
      if (bus.req_v) begin
        e_stall = 1'b1;
      end else if (bus.req_s) begin
        e_addr  = bus.addr_vec[N-1:0];
        e_wdata = bus.wdata_vec[N-1:0];
        e_we    = bus.we;
      end
    end else if (phase <= 4) begin
      e_addr  = m_addr[(phase-1)*N +: N];
      e_wdata = m_wdata[(phase-1)*N +: N];
      e_we    = m_we;
      e_stall = 1'b1;
    end else if (phase == 5) begin
      e_stall = 1'b1;
    end else begin
      e_done = 1'b1;
    end
    check("model mem_addr", V'(bus.mem_addr), V'(e_addr));
    check("model mem_wdata", V'(bus.mem_wdata), V'(e_wdata));
    check("model mem_we", V'(bus.mem_we), V'(e_we));
    check("model done", V'(bus.done), V'(e_done));
    check("model stall_cpu", V'(bus.stall_cpu), V'(e_stall));
    check("model rdata_vec", bus.rdata_vec, exp_rdata);

    if (rst) begin
      phase = -1;
      exp_rdata = '0;
    end else if (phase < 0) begin
      if (bus.req_v) begin
        phase   = 1;
        m_addr  = bus.addr_vec;
        m_wdata = bus.wdata_vec;
        m_we    = bus.we;
      end
    end else begin
      if (!m_we && phase >= 2 && phase <= 5) exp_rdata[(phase-2)*N +: N] = bus.mem_rdata;
      phase = (phase == 6) ? -1 : phase + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [V-1:0] LOAD_ADDR = {32'h0C, 32'h08, 32'h04, 32'h00};
  localparam logic [V-1:0] LOAD_DATA = {32'h44, 32'h33, 32'h22, 32'h11};

  initial begin
    int stall_ones;
    rst = 1'b1;
    bus.req_s = 1'b0; bus.req_v = 1'b0; bus.we = 1'b0;
    bus.addr_vec = '0; bus.wdata_vec = '0;

    // reset state
    @(negedge clk);
    check("reset mem_we", V'(bus.mem_we), V'(1'b0));
    check("reset stall_cpu", V'(bus.stall_cpu), V'(1'b0));
    check("reset rdata_vec", bus.rdata_vec, '0);
    next_cycle();
    rst = 1'b0;

    // idle, no request: bus must stay zero even with live operands
    bus.we = 1'b1; bus.addr_vec = {4{32'h3C}}; bus.wdata_vec = {4{32'hFF}};
    @(negedge clk);
    check("idle mem_addr", V'(bus.mem_addr), '0);
    check("idle mem_we", V'(bus.mem_we), '0);

    // vector load
    next_cycle();
    bus.req_v = 1'b1; bus.we = 1'b0; bus.addr_vec = LOAD_ADDR; bus.wdata_vec = '0;
    @(negedge clk);
    stall_ones = bus.stall_cpu ? 1 : 0;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 1) begin
        bus.req_v = 1'b0; bus.we = 1'b1; bus.addr_vec = {4{32'hFC}};
      end
      @(negedge clk);
      if (bus.stall_cpu) stall_ones++;
      if (k <= 4) check("vload mem_addr", V'(bus.mem_addr), V'(32'(4*(k-1))));
      if (k == 6) begin
        check("vload done", V'(bus.done), V'(1'b1));
        check("vload rdata", bus.rdata_vec, LOAD_DATA);
      end
    end
    check("vload stall cycles", V'(stall_ones), V'(6));
    bus.we = 1'b0;

    // scalar store
    next_cycle();
    bus.req_s = 1'b1; bus.we = 1'b1;
    bus.addr_vec = {96'h0, 32'h20}; bus.wdata_vec = {96'h0, 32'h5A};
    @(negedge clk);
    check("scalar mem_addr", V'(bus.mem_addr), V'(32'h20));
    check("scalar mem_wdata", V'(bus.mem_wdata), V'(32'h5A));
    check("scalar mem_we", V'(bus.mem_we), V'(1'b1));
    check("scalar stall_cpu", V'(bus.stall_cpu), V'(1'b0));
    next_cycle();
    bus.req_s = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    check("scalar stored word", V'(mem[8]), V'(32'h5A));

    // vector store; operands scrambled after T must not matter
    next_cycle();
    bus.req_v = 1'b1; bus.we = 1'b1;
    bus.addr_vec = {32'h3C, 32'h38, 32'h34, 32'h30};
    bus.wdata_vec = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    @(negedge clk);
    check("vstore mem_we T", V'(bus.mem_we), '0);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 1) begin
        bus.req_v = 1'b0; bus.we = 1'b0; bus.addr_vec = '0; bus.wdata_vec = '1;
      end
      @(negedge clk);
      check("vstore mem_we", V'(bus.mem_we), V'((k >= 1 && k <= 4) ? 1'b1 : 1'b0));
      if (k <= 4) check("vstore mem_wdata", V'(bus.mem_wdata), V'(32'hA1 + 32'(17*(k-1))));
    end
    check("vstore rdata kept", bus.rdata_vec, LOAD_DATA);
    check("vstore word A", V'(mem[12]), V'(32'hA1));
    check("vstore word D", V'(mem[15]), V'(32'hD4));

    // simultaneous req_s/req_v: vector wins, scalar pulses during BEAT ignored
    next_cycle();
    bus.req_s = 1'b1; bus.req_v = 1'b1; bus.we = 1'b0;
    bus.addr_vec = {32'h2C, 32'h28, 32'h24, 32'h20}; bus.wdata_vec = {4{32'h77}};
    @(negedge clk);
    check("both mem_addr T", V'(bus.mem_addr), '0);
    check("both stall T", V'(bus.stall_cpu), V'(1'b1));
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 1) begin
        bus.req_v = 1'b0; bus.we = 1'b1; bus.addr_vec = {4{32'h3C}};
      end
      if (k == 6) bus.req_s = 1'b0;
      @(negedge clk);
      if (k <= 4) begin
        check("both mem_we", V'(bus.mem_we), '0);
        check("both mem_addr", V'(bus.mem_addr), V'(32'h20 + 32'(4*(k-1))));
      end
      if (k == 6) check("both rdata", bus.rdata_vec, {32'h100B, 32'h100A, 32'h1009, 32'h5A});
    end
    bus.we = 1'b0;

    // reset at T+3 of a load, then a fresh load
    next_cycle();
    bus.req_v = 1'b1; bus.addr_vec = LOAD_ADDR;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      bus.req_v = 1'b0;
      rst = (k == 3);
    end
    @(negedge clk);
    check("abort mem_we", V'(bus.mem_we), '0);
    check("abort mem_addr", V'(bus.mem_addr), '0);
    check("abort stall", V'(bus.stall_cpu), '0);
    check("abort rdata", bus.rdata_vec, '0);
    next_cycle();
    @(negedge clk);
    check("abort quiet", V'(bus.mem_we), '0);
    next_cycle();
    bus.req_v = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      bus.req_v = 1'b0;
      @(negedge clk);
      if (k == 2) check("reload mem_addr", V'(bus.mem_addr), V'(32'h04));
    end
    check("reload done", V'(bus.done), V'(1'b1));
    check("reload rdata", bus.rdata_vec, LOAD_DATA);

    // back-to-back: req_v held through DONE is only accepted at T+7
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.req_v = 1'b1; bus.addr_vec = LOAD_ADDR;
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      if (k == 8) bus.req_v = 1'b0;
      @(negedge clk);
      if (k == 6 || k == 13) check("b2b done", V'(bus.done), V'(1'b1));
      if (k == 7) check("b2b restall", V'(bus.stall_cpu), V'(1'b1));
    end
    check("b2b rdata", bus.rdata_vec, LOAD_DATA);
`ifdef VMS_STALL_CNT_EN
    check("stall_cnt", V'(stall_cnt), V'(12));
`endif

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
